// File: rtl/pre_proc_join_pkg.sv
// Shared types and helpers for the pre-processing fork/join controller.
`ifndef PRE_PROC_LANE_W
`define PRE_PROC_LANE_W 64
`endif

package pre_proc_pkg;

    typedef enum logic {IDLE = 1'b0, COLLECT = 1'b1} join_state_t;

    typedef logic [`PRE_PROC_LANE_W-1:0] lane_payload_t;

    // Counters up to SAT_W bits share one saturating-increment helper.
    localparam int SAT_W = 32;

    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v,
                                                 input logic [SAT_W-1:0] max);
        return (v >= max) ? v : v + SAT_W'(1);
    endfunction

endpackage

// File: rtl/pre_proc_join_if.sv
// Token, lane and output handshake bundle for pre_proc_join.
interface pre_proc_join_if #(
    parameter int NUM_LANES  = 2,
    parameter int LANE_WIDTH = 64,
    parameter int TAG_WIDTH  = 11,
    parameter int CNT_WIDTH  = 16
);
    logic                                  valid_in;
    logic                                  ready_out;
    logic [TAG_WIDTH-1:0]                  tag_in;
    logic [NUM_LANES-1:0]                  lane_start_out;
    logic [NUM_LANES-1:0]                  lane_valid_in;
    logic [NUM_LANES-1:0]                  lane_ready_out;
    logic [NUM_LANES-1:0][LANE_WIDTH-1:0]  lane_data_in;
    logic [NUM_LANES-1:0]                  lane_cull_in;
    logic                                  valid_out;
    logic                                  ready_in;
    logic [NUM_LANES-1:0][LANE_WIDTH-1:0]  data_out;
    logic [TAG_WIDTH-1:0]                  tag_out;
    logic [CNT_WIDTH-1:0]                  cull_count_out;
    logic [CNT_WIDTH-1:0]                  accept_count_out;

    modport slave (
        input  valid_in, tag_in, lane_valid_in, lane_data_in, lane_cull_in, ready_in,
        output ready_out, lane_start_out, lane_ready_out, valid_out, data_out, tag_out,
               cull_count_out, accept_count_out
    );

    modport master (
        output valid_in, tag_in, lane_valid_in, lane_data_in, lane_cull_in, ready_in,
        input  ready_out, lane_start_out, lane_ready_out, valid_out, data_out, tag_out,
               cull_count_out, accept_count_out
    );
endinterface

// File: rtl/pre_proc_join_out_fifo.sv
// Synchronous output FIFO with count-based full/empty; any depth >= 1.
module join_out_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head,
    output logic                         valid,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
    assign valid   = (count != '0);
    assign head    = mem[rd_ptr];

    // Storage is cleared too so the head reads zero after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/pre_proc_join.sv
// N-lane fork/join: launch all lanes per triangle, gather results or drop on
// cull, and queue joined results toward the rasteriser.
module pre_proc_join
    import pre_proc_pkg::*;
#(
    parameter int NUM_LANES  = 2,
    parameter int LANE_WIDTH = 64,
    parameter int TAG_WIDTH  = 11,
    parameter int OUT_DEPTH  = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic            clk_in,
    input  logic            rst_in,
    pre_proc_join_if.slave  bus
);
    localparam int ENTRY_W = TAG_WIDTH + NUM_LANES * LANE_WIDTH;
    localparam int CW      = $clog2(OUT_DEPTH + 1);
    localparam logic [SAT_W-1:0] CNT_MAX = SAT_W'({CNT_WIDTH{1'b1}});

    join_state_t                          state;
    logic [TAG_WIDTH-1:0]                 tag_q;
    logic                                 start_q;
    logic [NUM_LANES-1:0]                 done;
    logic [NUM_LANES-1:0][LANE_WIDTH-1:0] data_q;
    logic [CNT_WIDTH-1:0]                 cull_cnt, acc_cnt;
    logic [CW-1:0]                        fifo_count;
    logic [ENTRY_W-1:0]                   head;
    logic                                 fifo_valid, accept, cull, complete;

    // FIFO space is reserved at accept, so completion can always push.
    assign bus.ready_out      = !rst_in && (state == IDLE) && (fifo_count < CW'(OUT_DEPTH));
    assign accept             = bus.valid_in && bus.ready_out;
    assign cull               = (state == COLLECT) && (|bus.lane_cull_in);
    assign complete           = (state == COLLECT) && (&done) && !cull;
    assign bus.lane_start_out = {NUM_LANES{start_q}};
    assign bus.lane_ready_out = (state == COLLECT) ? ~done : '0;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state    <= IDLE;
            tag_q    <= '0;
            start_q  <= 1'b0;
            cull_cnt <= '0;
            acc_cnt  <= '0;
        end else begin
            start_q <= accept;
            case (state)
                IDLE: if (accept) begin
                    tag_q <= bus.tag_in;
                    state <= COLLECT;
                end
                COLLECT: if (cull) begin
                    cull_cnt <= CNT_WIDTH'(sat_inc(SAT_W'(cull_cnt), CNT_MAX));
                    state    <= IDLE;
                end else if (&done) begin
                    acc_cnt <= CNT_WIDTH'(sat_inc(SAT_W'(acc_cnt), CNT_MAX));
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            done   <= '0;
            data_q <= '0;
        end else if (accept) begin
            done <= '0;
        end else if (state == COLLECT) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (bus.lane_valid_in[i] && !done[i]) begin
                    done[i]   <= 1'b1;
                    data_q[i] <= bus.lane_data_in[i];
                end
            end
        end
    end

    join_out_fifo #(.WIDTH(ENTRY_W), .DEPTH(OUT_DEPTH)) u_fifo (
        .clk       (clk_in),
        .rst       (rst_in),
        .push      (complete),
        .push_data ({tag_q, data_q}),
        .pop       (fifo_valid && bus.ready_in),
        .head      (head),
        .valid     (fifo_valid),
        .count     (fifo_count)
    );

    assign bus.valid_out        = fifo_valid;
    assign bus.data_out         = head[NUM_LANES*LANE_WIDTH-1:0];
    assign bus.tag_out          = head[ENTRY_W-1 -: TAG_WIDTH];
    assign bus.cull_count_out   = cull_cnt;
    assign bus.accept_count_out = acc_cnt;
endmodule
